// File: rtl/axi_read_master_if.sv
// AXI read (AR/R) channels plus packet-buffer write port for the packet fetch master.
interface axi_read_master_if;
  logic [3:0]   axi_arid;
  logic [31:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic [2:0]   axi_arsize;
  logic [1:0]   axi_arburst;
  logic [3:0]   axi_arcache;
  logic [2:0]   axi_arprot;
  logic         axi_arvld;
  logic         axi_arrdy;
  logic [3:0]   axi_rid;
  logic [511:0] axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast;
  logic         axi_rvld;
  logic         axi_rrdy;
  logic         pb_full;
  logic         pb_wr_en;
  logic [511:0] pb_wr_data;

  modport master (
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arcache,
           axi_arprot, axi_arvld, axi_rrdy, pb_wr_en, pb_wr_data,
    input  axi_arrdy, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvld, pb_full
  );

  modport slave (
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arcache,
           axi_arprot, axi_arvld, axi_rrdy, pb_wr_en, pb_wr_data,
    output axi_arrdy, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvld, pb_full
  );
endinterface

// File: rtl/axi_read_master.sv
// Fetches one packet (header flits then data flits) from SRAM over AXI into the packet buffer.
// Optional: define NOU_RD_ID_CHECK_EN to flag R beats whose rid differs from AXI_ID.
module axi_read_master #(
  parameter int          HDR_ADDR_W  = 12,
  parameter int          HDR_SZ_W    = 10,
  parameter int          DATA_ADDR_W = 12,
  parameter int          DATA_SZ_W   = 4,
  parameter logic [31:0] SRAM_BASE   = 32'h1000_0000,
  parameter logic [3:0]  AXI_ID      = 4'b0010,
  parameter int          MAX_OUTST   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_ar,
  output logic                   rd_done,
  output logic                   rd_err,
  input  logic [HDR_ADDR_W-1:0]  pkt_header_addr,
  input  logic [HDR_SZ_W-1:0]    pkt_header_sz,
  input  logic [DATA_ADDR_W-1:0] pkt_data_addr,
  input  logic [DATA_SZ_W-1:0]   pkt_data_sz,
  axi_read_master_if.master      bus
);
  localparam int HN_W  = HDR_SZ_W + 1;
  localparam int DN_W  = DATA_SZ_W + 5;
  localparam int CNT_W = ((HN_W > DN_W) ? HN_W : DN_W) + 1;
  localparam int OUT_W = 4;

  typedef enum logic [2:0] {IDLE, AR_HDR, AR_DATA, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hdr_n_q, hdr_n_d;
  logic [CNT_W-1:0]   dat_n_q, dat_n_d;
  logic [CNT_W-1:0]   tot_n_q, tot_n_d;
  logic [CNT_W-1:0]   ar_cnt_q, ar_cnt_d;
  logic [CNT_W-1:0]   r_cnt_q, r_cnt_d;
  logic [OUT_W-1:0]   outst_q, outst_d;
  logic [31:0]        araddr_q, araddr_d;
  logic [31:0]        dat_addr_q, dat_addr_d;
  logic               err_q, err_d;

  logic [HN_W-1:0]    hdr_n_calc;
  logic [DATA_SZ_W:0] dsz_p1;
  logic [DN_W-1:0]    dat_n_calc;
  logic [31:0]        hdr_base, dat_base;
  logic               ar_phase, outst_ok, arvld, rrdy, ar_hs, r_hs, beat_err;
  logic               unused_sig;

  assign hdr_n_calc = ({1'b0, pkt_header_sz} + HN_W'(64)) >> 6;
  assign dsz_p1     = {1'b0, pkt_data_sz} + 1'b1;
  assign dat_n_calc = {dsz_p1, 4'b0000};
  assign hdr_base   = 32'(pkt_header_addr) << 10;
  assign dat_base   = 32'(pkt_data_addr) << 10;

  // arvld depends only on state and outst, and outst cannot rise while an AR
  // waits, so a raised arvld stays up until its handshake.
  assign ar_phase = (state_q == AR_HDR) || (state_q == AR_DATA);
  assign outst_ok = outst_q < OUT_W'(MAX_OUTST);
  assign arvld    = ar_phase && outst_ok;
  assign rrdy     = !bus.pb_full && (state_q != IDLE);
  assign ar_hs    = arvld && bus.axi_arrdy;
  assign r_hs     = bus.axi_rvld && rrdy;

`ifdef NOU_RD_ID_CHECK_EN
  assign beat_err   = (bus.axi_rresp != 2'b00) || (bus.axi_rid != AXI_ID);
  assign unused_sig = bus.axi_rlast;
`else
  assign beat_err   = (bus.axi_rresp != 2'b00);
  assign unused_sig = ^{bus.axi_rlast, bus.axi_rid};
`endif

  assign bus.axi_arid    = AXI_ID;
  assign bus.axi_araddr  = araddr_q;
  assign bus.axi_arlen   = 8'd0;
  assign bus.axi_arsize  = 3'b110;
  assign bus.axi_arburst = 2'b01;
  assign bus.axi_arcache = 4'b0010;
  assign bus.axi_arprot  = 3'd0;
  assign bus.axi_arvld   = arvld;
  assign bus.axi_rrdy    = rrdy;
  assign bus.pb_wr_en    = r_hs;
  assign bus.pb_wr_data  = bus.axi_rdata;

  assign rd_done = (state_q == DONE);
  assign rd_err  = (state_q == DONE) && err_q;

  always_comb begin
    state_d    = state_q;
    hdr_n_d    = hdr_n_q;
    dat_n_d    = dat_n_q;
    tot_n_d    = tot_n_q;
    ar_cnt_d   = ar_cnt_q;
    araddr_d   = araddr_q;
    dat_addr_d = dat_addr_q;
    r_cnt_d    = r_cnt_q + CNT_W'(r_hs);
    outst_d    = outst_q + OUT_W'(ar_hs) - OUT_W'(r_hs);
    err_d      = err_q || (r_hs && beat_err);

    case (state_q)
      IDLE: begin
        if (start_ar) begin
          state_d    = AR_HDR;
          hdr_n_d    = CNT_W'(hdr_n_calc);
          dat_n_d    = CNT_W'(dat_n_calc);
          tot_n_d    = CNT_W'(hdr_n_calc) + CNT_W'(dat_n_calc);
          ar_cnt_d   = '0;
          r_cnt_d    = '0;
          outst_d    = '0;
          err_d      = 1'b0;
          araddr_d   = SRAM_BASE + hdr_base;
          dat_addr_d = SRAM_BASE + dat_base;
        end
      end
      AR_HDR: begin
        if (ar_hs) begin
          if (ar_cnt_q == hdr_n_q - CNT_W'(1)) begin
            state_d  = AR_DATA;
            ar_cnt_d = '0;
            araddr_d = dat_addr_q;
          end else begin
            ar_cnt_d = ar_cnt_q + CNT_W'(1);
            araddr_d = araddr_q + 32'd64;
          end
        end
      end
      AR_DATA: begin
        if (ar_hs) begin
          if (ar_cnt_q == dat_n_q - CNT_W'(1)) begin
            // A same-cycle final R (zero-latency slave) goes straight to DONE.
            state_d = (r_cnt_d == tot_n_q) ? DONE : DRAIN;
          end else begin
            ar_cnt_d = ar_cnt_q + CNT_W'(1);
            araddr_d = araddr_q + 32'd64;
          end
        end
      end
      DRAIN: begin
        // Look at the post-increment count so rd_done lands one cycle after the last beat.
        if (r_cnt_d == tot_n_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hdr_n_q    <= '0;
      dat_n_q    <= '0;
      tot_n_q    <= '0;
      ar_cnt_q   <= '0;
      r_cnt_q    <= '0;
      outst_q    <= '0;
      araddr_q   <= '0;
      dat_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_n_q    <= hdr_n_d;
      dat_n_q    <= dat_n_d;
      tot_n_q    <= tot_n_d;
      ar_cnt_q   <= ar_cnt_d;
      r_cnt_q    <= r_cnt_d;
      outst_q    <= outst_d;
      araddr_q   <= araddr_d;
      dat_addr_q <= dat_addr_d;
      err_q      <= err_d;
    end
  end
endmodule
